// File: rtl/matrix_stack_unit_if.sv
// Command, load-row, write-back, peek and error signals of matrix_stack_unit.
interface matrix_stack_unit_if #(
  parameter int ELEM_W     = 32,
  parameter int DEPTH      = 8,
  parameter int NUM_STACKS = 2
);
  localparam int ROW_W = 4 * ELEM_W;
  localparam int SEL_W = (NUM_STACKS > 1) ? $clog2(NUM_STACKS) : 1;
  localparam int DEP_W = $clog2(DEPTH) + 1;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [SEL_W-1:0] cmd_sel;
  logic             row_valid;
  logic             row_ready;
  logic [ROW_W-1:0] data_in;
  logic [ROW_W-1:0] write_in_0;
  logic [ROW_W-1:0] write_in_1;
  logic [ROW_W-1:0] write_in_2;
  logic [ROW_W-1:0] write_in_3;
  logic [SEL_W-1:0] peek_sel;
  logic [ROW_W-1:0] peek_out_0;
  logic [ROW_W-1:0] peek_out_1;
  logic [ROW_W-1:0] peek_out_2;
  logic [ROW_W-1:0] peek_out_3;
  logic [DEP_W-1:0] peek_depth;
  logic             err_overflow;
  logic             err_underflow;
  logic [1:0]       err_sticky;
  logic             err_clr;

  modport master (
    output cmd_valid, cmd_op, cmd_sel, row_valid, data_in,
           write_in_0, write_in_1, write_in_2, write_in_3, peek_sel, err_clr,
    input  cmd_ready, row_ready, peek_out_0, peek_out_1, peek_out_2, peek_out_3,
           peek_depth, err_overflow, err_underflow, err_sticky
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_sel, row_valid, data_in,
           write_in_0, write_in_1, write_in_2, write_in_3, peek_sel, err_clr,
    output cmd_ready, row_ready, peek_out_0, peek_out_1, peek_out_2, peek_out_3,
           peek_depth, err_overflow, err_underflow, err_sticky
  );
endinterface

// File: rtl/matrix_stack_unit.sv
// NUM_STACKS independent stacks of 4x4 matrices with push-duplicate, pop, load and write-back.
// Define MATRIX_STACK_ERR_EN to enable the overflow/underflow pulses and sticky flags.
module matrix_stack_unit #(
  parameter int                ELEM_W     = 32,
  parameter int                DEPTH      = 8,
  parameter int                NUM_STACKS = 2,
  parameter logic [ELEM_W-1:0] ONE_VAL    = 32'h3F800000
) (
  input  logic               clk,
  input  logic               reset,
  matrix_stack_unit_if.slave bus
);
  localparam int ROW_W = 4 * ELEM_W;
  localparam int SEL_W = (NUM_STACKS > 1) ? $clog2(NUM_STACKS) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);
  localparam logic [SEL_W:0]   STK_CNT = (SEL_W + 1)'(NUM_STACKS);

  typedef enum logic [3:0] {
    ST_IDLE, ST_COPY0, ST_COPY1, ST_COPY2, ST_COPY3,
    ST_LOAD0, ST_LOAD1, ST_LOAD2, ST_LOAD3
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP, OP_PUSH, OP_POP, OP_LOAD_ID, OP_LOAD, OP_WRITE
  } op_t;

  state_t           state_q;
  logic             cmd_ready_q;
  logic             row_ready_q;
  logic [SEL_W-1:0] sel_q;
  logic [PTR_W-1:0] ptr_q [NUM_STACKS];
  logic [ROW_W-1:0] mem_q [NUM_STACKS][DEPTH][4];

  logic             sel_ok, peek_ok, accept, ovf_hit, unf_hit;
  logic [PTR_W-1:0] top_cmd, top_lat, top_nxt;
  logic [1:0]       row_k;
  logic [ROW_W-1:0] wr_rows [4];

  // Element 0 lands in the most significant ELEM_W bits after four shifts.
  function automatic logic [ROW_W-1:0] id_row(input int unsigned r);
    logic [ROW_W-1:0] f;
    f = '0;
    for (int unsigned e = 0; e < 4; e++)
      f = {f[ROW_W-ELEM_W-1:0], (e == r) ? ONE_VAL : {ELEM_W{1'b0}}};
    return f;
  endfunction

  assign sel_ok  = ({1'b0, bus.cmd_sel} < STK_CNT);
  assign peek_ok = ({1'b0, bus.peek_sel} < STK_CNT);
  assign accept  = bus.cmd_valid && cmd_ready_q && sel_ok;
  assign top_cmd = ptr_q[bus.cmd_sel];
  assign top_lat = ptr_q[sel_q];
  assign top_nxt = top_lat + PTR_W'(1);
  assign ovf_hit = accept && (bus.cmd_op == OP_PUSH) && (top_cmd == PTR_MAX);
  assign unf_hit = accept && (bus.cmd_op == OP_POP) && (top_cmd == '0);

  assign wr_rows[0] = bus.write_in_0;
  assign wr_rows[1] = bus.write_in_1;
  assign wr_rows[2] = bus.write_in_2;
  assign wr_rows[3] = bus.write_in_3;

  always_comb begin
    row_k = 2'd0;
    case (state_q)
      ST_COPY1, ST_LOAD1: row_k = 2'd1;
      ST_COPY2, ST_LOAD2: row_k = 2'd2;
      ST_COPY3, ST_LOAD3: row_k = 2'd3;
      default:            row_k = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      row_ready_q <= 1'b0;
      sel_q       <= '0;
      for (int unsigned s = 0; s < NUM_STACKS; s++) begin
        ptr_q[s] <= '0;
        for (int unsigned l = 0; l < DEPTH; l++)
          for (int unsigned r = 0; r < 4; r++)
            mem_q[s][l][r] <= (l == 0) ? id_row(r) : '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            case (bus.cmd_op)
              OP_PUSH: begin
                if (!ovf_hit) begin
                  sel_q       <= bus.cmd_sel;
                  state_q     <= ST_COPY0;
                  cmd_ready_q <= 1'b0;
                end
              end
              OP_POP: begin
                if (!unf_hit) ptr_q[bus.cmd_sel] <= top_cmd - PTR_W'(1);
              end
              OP_LOAD_ID: begin
                for (int unsigned r = 0; r < 4; r++)
                  mem_q[bus.cmd_sel][top_cmd][r] <= id_row(r);
              end
              OP_WRITE: begin
                for (int unsigned r = 0; r < 4; r++)
                  mem_q[bus.cmd_sel][top_cmd][r] <= wr_rows[r];
              end
              OP_LOAD: begin
                sel_q       <= bus.cmd_sel;
                state_q     <= ST_LOAD0;
                cmd_ready_q <= 1'b0;
                row_ready_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_COPY0, ST_COPY1, ST_COPY2, ST_COPY3: begin
          mem_q[sel_q][top_nxt][row_k] <= mem_q[sel_q][top_lat][row_k];
          if (state_q == ST_COPY3) begin
            ptr_q[sel_q] <= top_nxt;
            state_q      <= ST_IDLE;
            cmd_ready_q  <= 1'b1;
          end else begin
            state_q <= state_t'(state_q + 4'd1);
          end
        end
        ST_LOAD0, ST_LOAD1, ST_LOAD2, ST_LOAD3: begin
          if (bus.row_valid) begin
            mem_q[sel_q][top_lat][row_k] <= bus.data_in;
            if (state_q == ST_LOAD3) begin
              state_q     <= ST_IDLE;
              cmd_ready_q <= 1'b1;
              row_ready_q <= 1'b0;
            end else begin
              state_q <= state_t'(state_q + 4'd1);
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
          row_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.row_ready = row_ready_q;

  always_comb begin
    bus.peek_out_0 = '0;
    bus.peek_out_1 = '0;
    bus.peek_out_2 = '0;
    bus.peek_out_3 = '0;
    bus.peek_depth = '0;
    if (peek_ok) begin
      bus.peek_out_0 = mem_q[bus.peek_sel][ptr_q[bus.peek_sel]][0];
      bus.peek_out_1 = mem_q[bus.peek_sel][ptr_q[bus.peek_sel]][1];
      bus.peek_out_2 = mem_q[bus.peek_sel][ptr_q[bus.peek_sel]][2];
      bus.peek_out_3 = mem_q[bus.peek_sel][ptr_q[bus.peek_sel]][3];
      bus.peek_depth = {1'b0, ptr_q[bus.peek_sel]};
    end
  end

`ifdef MATRIX_STACK_ERR_EN
  logic       ovf_q, unf_q;
  logic [1:0] sticky_q;

  // err_clr wins over a same-cycle error; the pulse still fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      sticky_q <= '0;
    end else begin
      ovf_q <= ovf_hit;
      unf_q <= unf_hit;
      if (bus.err_clr) sticky_q <= '0;
      else             sticky_q <= sticky_q | {unf_hit, ovf_hit};
    end
  end

  assign bus.err_overflow  = ovf_q;
  assign bus.err_underflow = unf_q;
  assign bus.err_sticky    = sticky_q;
`else
  logic unused_err_clr;
  assign unused_err_clr    = bus.err_clr;
  assign bus.err_overflow  = 1'b0;
  assign bus.err_underflow = 1'b0;
  assign bus.err_sticky    = 2'b00;
`endif
endmodule

// File: tb/tb_matrix_stack_unit.sv
// Self-checking bench for matrix_stack_unit: matrix-level reference model plus directed literal checks.
module tb_matrix_stack_unit;
  localparam int NS    = 2;
  localparam int DEPTH = 8;
  localparam logic [31:0] ONE = 32'h3F800000;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  matrix_stack_unit_if #(.ELEM_W(32), .DEPTH(DEPTH), .NUM_STACKS(NS)) bus ();

  matrix_stack_unit #(.ELEM_W(32), .DEPTH(DEPTH), .NUM_STACKS(NS), .ONE_VAL(ONE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: whole stacks of matrices, updated once per clock edge.
  logic [127:0] m_mat [NS][DEPTH][4];
  int           m_ptr [NS];
  int           m_push_left, m_load_row, m_lsel;
  bit           m_ovf, m_unf, m_init;
  logic [1:0]   m_sticky;

  function automatic logic [127:0] ident(input int r);
    logic [127:0] v;
    v = '0;
    for (int e = 0; e < 4; e++)
      if (e == r) v[127 - 32*e -: 32] = ONE;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] peek_row(input int r);
    case (r)
      0:       return bus.peek_out_0;
      1:       return bus.peek_out_1;
      2:       return bus.peek_out_2;
      default: return bus.peek_out_3;
    endcase
  endfunction

  always @(posedge clk) begin
    bit o, u;
    int s, p;
    o = 0;
    u = 0;
    if (reset) begin
      for (int i = 0; i < NS; i++) begin
        m_ptr[i] = 0;
        for (int l = 0; l < DEPTH; l++)
          for (int r = 0; r < 4; r++) m_mat[i][l][r] = (l == 0) ? ident(r) : '0;
      end
      m_push_left = 0;
      m_load_row  = 4;
      m_lsel      = 0;
      m_sticky    = 2'b00;
      m_init      = 1;
    end else if (m_init) begin
      if (m_push_left > 0) begin
        m_push_left--;
        if (m_push_left == 0) begin
          p = m_ptr[m_lsel];
          for (int r = 0; r < 4; r++) m_mat[m_lsel][p+1][r] = m_mat[m_lsel][p][r];
          m_ptr[m_lsel] = p + 1;
        end
      end else if (m_load_row < 4) begin
        if (bus.row_valid) begin
          m_mat[m_lsel][m_ptr[m_lsel]][m_load_row] = bus.data_in;
          m_load_row++;
        end
      end else if (bus.cmd_valid && int'(bus.cmd_sel) < NS) begin
        s = int'(bus.cmd_sel);
        p = m_ptr[s];
        case (bus.cmd_op)
          3'd1: if (p == DEPTH - 1) o = 1; else begin m_push_left = 4; m_lsel = s; end
          3'd2: if (p == 0) u = 1; else m_ptr[s] = p - 1;
          3'd3: for (int r = 0; r < 4; r++) m_mat[s][p][r] = ident(r);
          3'd4: begin m_load_row = 0; m_lsel = s; end
          3'd5: begin
            m_mat[s][p][0] = bus.write_in_0;
            m_mat[s][p][1] = bus.write_in_1;
            m_mat[s][p][2] = bus.write_in_2;
            m_mat[s][p][3] = bus.write_in_3;
          end
          default: ;
        endcase
      end
      if (bus.err_clr) m_sticky = 2'b00;
      else             m_sticky = m_sticky | {u, o};
    end
    m_ovf = o;
    m_unf = u;
  end

  // Compare process: every cycle the model is live, away from the active edge.
  always @(negedge clk) begin
    int ps;
    logic [1:0] e_st;
    bit e_o, e_u;
    if (m_init && !reset) begin
      ps = int'(bus.peek_sel);
      chk("cmd_ready", 128'(bus.cmd_ready), 128'(m_push_left == 0 && m_load_row == 4));
      chk("row_ready", 128'(bus.row_ready), 128'(m_load_row < 4));
      for (int r = 0; r < 4; r++)
        chk($sformatf("peek_row%0d", r), peek_row(r), (ps < NS) ? m_mat[ps][m_ptr[ps]][r] : '0);
      chk("peek_depth", 128'(bus.peek_depth), (ps < NS) ? 128'(m_ptr[ps]) : '0);
`ifdef MATRIX_STACK_ERR_EN
      e_o = m_ovf; e_u = m_unf; e_st = m_sticky;
`else
      e_o = 0; e_u = 0; e_st = 2'b00;
`endif
      chk("err_overflow", 128'(bus.err_overflow), 128'(e_o));
      chk("err_underflow", 128'(bus.err_underflow), 128'(e_u));
      chk("err_sticky", 128'(bus.err_sticky), 128'(e_st));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [2:0] op, input logic sel);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_sel   = sel;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 16 && !bus.cmd_ready; i++) tick();
    chk("wait_idle_bound", 128'(bus.cmd_ready), 128'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] rows_abcd [4];
    logic [127:0] load_rows [4];
    bit           pat [7];
    int           k;
    logic [1:0]   exp_st;
    logic         exp_p;

    rows_abcd = '{128'hA0000001_A0000002_A0000003_A0000004, 128'hB0000001_B0000002_B0000003_B0000004,
                  128'hC0000001_C0000002_C0000003_C0000004, 128'hD0000001_D0000002_D0000003_D0000004};
    load_rows = '{{4{32'h11111111}}, {4{32'h22222222}}, {4{32'h33333333}}, {4{32'h44444444}}};
    pat = '{1, 0, 1, 0, 0, 1, 1};

    reset = 1'b1;
    bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_sel = 0; bus.row_valid = 0; bus.data_in = '0;
    bus.write_in_0 = '0; bus.write_in_1 = '0; bus.write_in_2 = '0; bus.write_in_3 = '0;
    bus.peek_sel = 0; bus.err_clr = 0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_peek0", bus.peek_out_0, 128'h3F800000_00000000_00000000_00000000);
    chk("rst_peek3", bus.peek_out_3, 128'h00000000_00000000_00000000_3F800000);
    chk("rst_depth", 128'(bus.peek_depth), 128'(0));
    chk("rst_cmd_ready", 128'(bus.cmd_ready), 128'(1));

    // WRITE, PUSH duplicate, LOAD_ID, POP back to the written matrix.
    tick();
    bus.write_in_0 = rows_abcd[0]; bus.write_in_1 = rows_abcd[1];
    bus.write_in_2 = rows_abcd[2]; bus.write_in_3 = rows_abcd[3];
    issue(3'd5, 1'b0);
    issue(3'd1, 1'b0);
    @(negedge clk);
    chk("push_busy", 128'(bus.cmd_ready), 128'(0));
    tick();
    wait_idle();
    @(negedge clk);
    chk("push_depth", 128'(bus.peek_depth), 128'(1));
    chk("push_row0", bus.peek_out_0, rows_abcd[0]);
    chk("push_row3", bus.peek_out_3, rows_abcd[3]);
    tick();
    issue(3'd3, 1'b0);
    issue(3'd2, 1'b0);
    @(negedge clk);
    chk("pop_depth", 128'(bus.peek_depth), 128'(0));
    chk("pop_row1", bus.peek_out_1, rows_abcd[1]);
    chk("pop_row2", bus.peek_out_2, rows_abcd[2]);

    // LOAD stack 1 with row_valid gaps.
    tick();
    bus.peek_sel = 1'b1;
    issue(3'd4, 1'b1);
    k = 0;
    for (int i = 0; i < 7; i++) begin
      bus.row_valid = pat[i];
      bus.data_in   = load_rows[k];
      tick();
      if (pat[i]) k++;
    end
    bus.row_valid = 1'b0;
    @(negedge clk);
    chk("load_row0", bus.peek_out_0, load_rows[0]);
    chk("load_row3", bus.peek_out_3, load_rows[3]);
    chk("load_row_ready", 128'(bus.row_ready), 128'(0));

    // Fill stack 0 to the top, then overflow.
    tick();
    bus.peek_sel = 1'b0;
    for (int i = 0; i < 7; i++) begin
      issue(3'd1, 1'b0);
      wait_idle();
    end
    issue(3'd1, 1'b0);
    @(negedge clk);
`ifdef MATRIX_STACK_ERR_EN
    exp_p = 1'b1; exp_st = 2'b01;
`else
    exp_p = 1'b0; exp_st = 2'b00;
`endif
    chk("ovf_pulse", 128'(bus.err_overflow), 128'(exp_p));
    chk("ovf_sticky", 128'(bus.err_sticky), 128'(exp_st));
    chk("ovf_depth", 128'(bus.peek_depth), 128'(7));
    chk("ovf_ready", 128'(bus.cmd_ready), 128'(1));
    tick();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    @(negedge clk);
    chk("clr_sticky", 128'(bus.err_sticky), 128'(0));

    // Reset in the middle of a LOAD.
    tick();
    issue(3'd4, 1'b0);
    bus.row_valid = 1'b1;
    bus.data_in   = {4{32'hDEADBEEF}};
    tick();
    bus.row_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rstload_row_ready", 128'(bus.row_ready), 128'(0));
    chk("rstload_cmd_ready", 128'(bus.cmd_ready), 128'(1));
    chk("rstload_depth", 128'(bus.peek_depth), 128'(0));
    chk("rstload_row0", bus.peek_out_0, 128'h3F800000_00000000_00000000_00000000);

    // Underflow on a fresh stack.
    tick();
    bus.peek_sel = 1'b1;
    issue(3'd2, 1'b1);
    @(negedge clk);
    chk("unf_pulse", 128'(bus.err_underflow), 128'(exp_p));
    chk("unf_depth", 128'(bus.peek_depth), 128'(0));
    chk("unf_row2", bus.peek_out_2, 128'h00000000_00000000_3F800000_00000000);

    // Randomised traffic against the model.
    tick();
    for (int i = 0; i < 1500; i++) begin
      reset          = ($urandom_range(0, 199) == 0);
      bus.cmd_valid  = $urandom_range(0, 3) != 0;
      bus.cmd_op     = 3'($urandom_range(0, 7));
      bus.cmd_sel    = 1'($urandom_range(0, 1));
      bus.row_valid  = $urandom_range(0, 1) == 1;
      bus.data_in    = {$urandom, $urandom, $urandom, $urandom};
      bus.write_in_0 = {$urandom, $urandom, $urandom, $urandom};
      bus.write_in_1 = {$urandom, $urandom, $urandom, $urandom};
      bus.write_in_2 = {$urandom, $urandom, $urandom, $urandom};
      bus.write_in_3 = {$urandom, $urandom, $urandom, $urandom};
      bus.peek_sel   = 1'($urandom_range(0, 1));
      bus.err_clr    = ($urandom_range(0, 7) == 0);
      tick();
    end
    reset = 1'b0;
    bus.cmd_valid = 1'b0;
    tick();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/matrix_stack_unit.md
Name: matrix_stack_unit

Overview:
- Parametrised successor to the fixed two-stack matrix controller: NUM_STACKS independent 4x4 matrix stacks, each DEPTH matrices deep.
- Uses a valid/ready command handshake and implements a true glPushMatrix, which duplicates the top matrix.
- Detects overflow and underflow; streaming glLoadMatrix overwrites the top matrix in place.
- Sits between the GL command decoder and the transform datapath. The datapath reads the top matrix combinationally and writes back products via CMD_WRITE.

Parameters:
- ELEM_W, 32, bits per matrix element; a row is 4 elements, ROW_W = 4*ELEM_W.
- DEPTH, 8, matrices per stack; power of 2, at least 2.
- NUM_STACKS, 2, number of stacks; 0 = modelview, 1 = projection, 2 = texture, etc.
- ONE_VAL, 32'h3F800000, encoding of 1.0 used for identity diagonals.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  unit can accept a command
- cmd_op  in  3  0 NOP, 1 PUSH, 2 POP, 3 LOAD_ID, 4 LOAD, 5 WRITE; 6-7 behave as NOP
- cmd_sel  in  max(1,$clog2(NUM_STACKS))  target stack of the command
- row_valid  in  1  LOAD row present on data_in
- row_ready  out  1  unit accepts a LOAD row
- data_in  in  ROW_W  LOAD row data
- write_in_0..3  in  ROW_W  WRITE rows 0..3
- peek_sel  in  max(1,$clog2(NUM_STACKS))  stack shown on peek outputs
- peek_out_0..3  out  ROW_W  top matrix of stack peek_sel, rows 0..3
- peek_depth  out  $clog2(DEPTH)+1  occupied levels minus 1 of stack peek_sel
- err_overflow, err_underflow  out  1  one-cycle error pulses
- err_sticky  out  2  {underflow, overflow} sticky flags
- err_clr  in  1  clears err_sticky

Behaviour:
- Reset behaviour:
  - Reset is synchronous, active-high, and is already decided.
  - Every stack is set to level 0 = identity; all other levels become 0.
  - Every stack's top pointer is set to 0.
  - State goes to IDLE; cmd_ready = 1, row_ready = 0; error pulses and err_sticky = 0.
  - Reset aborts any in-flight PUSH or LOAD.
- Identity definition: row r has ONE_VAL in element r and 0 elsewhere. Element 0 is the most significant ELEM_W bits.
- Handshake:
  - A command is accepted when cmd_valid && cmd_ready.
  - cmd_ready = 1 only in IDLE.
- Peek path:
  - peek_out_* and peek_depth are combinational from the current storage and top pointer of stack peek_sel.
  - Row 0 is peek_out_0.
- State IDLE, single-cycle commands (the stack is written at the accepting edge; the unit stays in IDLE):
  - LOAD_ID: top matrix of cmd_sel becomes identity.
  - WRITE: top matrix of cmd_sel becomes write_in_0..3.
  - POP: top pointer decrements.
  - Underflow: POP at pointer 0 leaves storage and pointer unchanged and pulses err_underflow.
- PUSH, accepted in IDLE:
  - Overflow: PUSH at pointer DEPTH-1 is not executed; err_overflow pulses and the unit stays in IDLE.
  - Otherwise the unit enters COPY0..COPY3 and copies row k of level p to level p+1, one row per cycle.
  - On COPY3 the pointer increments and the unit returns to IDLE: 4 cycles busy, cmd_ready = 0.
  - Peek shows the old top (identical content) throughout.
- LOAD, accepted in IDLE: the unit enters LOAD0..LOAD3.
  - row_ready = 1 in LOADk.
  - On row_valid, data_in is written to row k of the top of the latched stack and the unit advances.
  - After LOAD3 it returns to IDLE.
  - Peek reflects rows as they are written. row_valid is ignored outside LOAD states.
- The target stack index is latched at acceptance. cmd_sel and cmd_op changes during PUSH or LOAD are ignored.
- An operation on one stack never alters any other stack.
- err_clr has priority over a same-cycle error set: it clears err_sticky, and the pulse output still fires.
- cmd_sel or peek_sel at or above NUM_STACKS: commands act as NOP, and peek returns 0.

Optional Feature:
- Macro: MATRIX_STACK_ERR_EN.
- Defined: error pulses and err_sticky behave as above.
- Undefined:
  - err_overflow, err_underflow and err_sticky are tied to 0; err_clr is ignored and no sticky registers are synthesised.
  - Illegal PUSH and POP are still suppressed, so storage is never corrupted.

Test Plan:
- Reset, peek_sel = 0 -> peek_out_0 = 3F800000_00000000_00000000_00000000, peek_out_3 = 00000000_00000000_00000000_3F800000, peek_depth = 0, cmd_ready = 1.
- WRITE rows A,B,C,D to stack 0, then PUSH -> cmd_ready low for 4 cycles, peek_depth = 1, peek rows A,B,C,D; then LOAD_ID, then POP -> peek rows A,B,C,D, depth 0.
- LOAD on stack 1 with row_valid gaps (rows 11..,22..,33..,44.. over 7 cycles) -> row_ready only in LOAD states, stack 1 top = those rows, stack 0 unchanged.
- PUSH x7 on stack 0 (DEPTH=8) then an 8th PUSH -> err_overflow 1-cycle pulse, err_sticky = 2'b01, depth stays 7; err_clr -> 2'b00.
- POP on a fresh stack -> err_underflow pulse, depth 0, contents still identity; repeat with macro undefined -> no pulse, same storage.
- Assert reset during LOAD1 -> next cycle IDLE, all stacks identity, depth 0, row_ready = 0.
